// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants and state encoding for the data-memory access controller.
// Keeps the Memory geometry and the fault-check width in one place.
package mem_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 16;
  localparam int REQ_ADDR_W = 16;
  // Upper request-address bits that must be zero for an in-range access.
  localparam int FAULT_W    = REQ_ADDR_W - MEM_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake between the load/store stage and the controller.
// master = load/store stage, slave = mem_access_ctrl.
interface mem_access_ctrl_if
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W
);

  logic                  ReqValid;
  logic                  ReqReady;
  logic                  ReqWrite;
  logic [REQ_ADDR_W-1:0] ReqAddr;
  logic [DATA_W-1:0]     ReqData;
  logic                  RespValid;
  logic                  RespReady;
  logic [DATA_W-1:0]     RespData;
  logic                  RespFault;

  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqData, RespReady,
    input  ReqReady, RespValid, RespData, RespFault
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqAddr, ReqData, RespReady,
    output ReqReady, RespValid, RespData, RespFault
  );

endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding front end for the 1K x 16 Memory: range check, one-cycle write, READ_LAT read.
// Response in 1 (fault) / 2 (store) / READ_LAT+1 (load) cycles; ReqReady low until the response is taken.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W   = MEM_DATA_W,
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int READ_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 Reset_n,
  mem_access_ctrl_if.slave     req_if,
  output logic [ADDR_W-1:0]    Addra,
  output logic [DATA_W-1:0]    DataIn,
  output logic                 WriteEnable,
  input  logic [DATA_W-1:0]    DataOut
);

  localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                resp_vld_q, resp_vld_d;
  logic                fault_q, fault_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic accept;
  logic is_fault;

  assign accept   = req_if.ReqValid & ready_q;
  assign is_fault = |req_if.ReqAddr[REQ_ADDR_W-1:ADDR_W];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    resp_vld_d = resp_vld_q;
    fault_d    = fault_q;
    rdata_d    = rdata_q;
    din_d      = din_q;
    addr_d     = addr_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          ready_d = 1'b0;
          addr_d  = req_if.ReqAddr[ADDR_W-1:0];
          din_d   = req_if.ReqData;
          if (is_fault) begin
            state_d    = RESP;
            resp_vld_d = 1'b1;
            fault_d    = 1'b1;
            rdata_d    = '0;
          end else if (req_if.ReqWrite) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
            cnt_d   = LAT_INIT;
          end
        end
      end
      WRITE: begin
        state_d    = RESP;
        resp_vld_d = 1'b1;
        fault_d    = 1'b0;
        rdata_d    = '0;
      end
      READ: begin
        // Addra has been stable for READ_LAT cycles when the counter expires.
        if (cnt_q == 2'd0) begin
          state_d    = RESP;
          resp_vld_d = 1'b1;
          fault_d    = 1'b0;
          rdata_d    = DataOut;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (req_if.RespReady) begin
          state_d    = IDLE;
          resp_vld_d = 1'b0;
          ready_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      ready_q    <= 1'b0;
      resp_vld_q <= 1'b0;
      fault_q    <= 1'b0;
      rdata_q    <= '0;
      din_q      <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      resp_vld_q <= resp_vld_d;
      fault_q    <= fault_d;
      rdata_q    <= rdata_d;
      din_q      <= din_d;
      addr_q     <= addr_d;
    end
  end

  assign WriteEnable      = (state_q == WRITE);
  assign Addra            = addr_q;
  assign DataIn           = din_q;
  assign req_if.ReqReady  = ready_q;
  assign req_if.RespValid = resp_vld_q;
  assign req_if.RespData  = rdata_q;
  assign req_if.RespFault = fault_q;

endmodule
